// File: rtl/magnetron_sequencer.sv
// Microwave magnetron sequencer: start/pause/stop/door handling with a seconds countdown,
// driving a downstream SR latch through single-cycle S/R pulses.
module magnetron_sequencer #(
    parameter int CLK_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic [11:0] time_in,
    output logic        S,
    output logic        R,
    output logic [11:0] time_left,
    output logic        done,
    output logic [1:0]  state
);

    localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_PER_SEC - 1);
    localparam logic [11:0]   MAX_TIME = 12'd3599;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COOK   = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [11:0]   time_left_q, time_left_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          done_q, done_d;
    logic          start_q, stop_q;
    logic          start_edge_s, stop_edge_s;

    assign start_edge_s = start & ~start_q;
    assign stop_edge_s  = stop & ~stop_q;

    // Next-state logic; priority in COOKING is stop, then door open, then terminal count.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        prescaler_d = prescaler_q;
        s_d         = 1'b0;
        r_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s && door_closed && (time_in != 12'd0)) begin
                    state_d     = ST_COOK;
                    time_left_d = (time_in > MAX_TIME) ? MAX_TIME : time_in;
                    prescaler_d = '0;
                    s_d         = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOK: begin
                if (stop_edge_s) begin
                    state_d     = ST_IDLE;
                    time_left_d = 12'd0;
                    prescaler_d = '0;
                    r_d         = 1'b1;
                end else if (!door_closed) begin
                    state_d = ST_PAUSED;
                    r_d     = 1'b1;
                end else if (prescaler_q == PRE_MAX) begin
                    prescaler_d = '0;
                    // <= 1 rather than == 1 so a zero count can never wrap around
                    if (time_left_q <= 12'd1) begin
                        time_left_d = 12'd0;
                        state_d     = ST_DONE;
                        r_d         = 1'b1;
                    end else begin
                        time_left_d = time_left_q - 12'd1;
                    end
                end else begin
                    prescaler_d = prescaler_q + PW'(1);
                end
            end
            ST_PAUSED: begin
                if (stop_edge_s) begin
                    state_d     = ST_IDLE;
                    time_left_d = 12'd0;
                    prescaler_d = '0;
                end else if (start_edge_s && door_closed) begin
                    state_d = ST_COOK;
                    s_d     = 1'b1;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (stop_edge_s || !door_closed) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                time_left_d = 12'd0;
                prescaler_d = '0;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; button history resets high so held buttons give no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            time_left_q <= 12'd0;
            prescaler_q <= '0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            prescaler_q <= prescaler_d;
            s_q         <= s_d;
            r_q         <= r_d;
            done_q      <= done_d;
            start_q     <= start;
            stop_q      <= stop;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign time_left = time_left_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: doc/magnetron_sequencer.md
MAGNETRON_SEQUENCER -- requirements
Module: magnetron_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_PER_SEC, default 50000000, meaning clock cycles per cooking second (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, start/resume button level (synchronous, debounced upstream).
REQ-005 The block SHALL have port stop, input, 1, stop/cancel button level.
REQ-006 The block SHALL have port door_closed, input, 1, 1 = door closed.
REQ-007 The block SHALL have port time_in, input, 12, programmed cook time in seconds.
REQ-008 The block SHALL have port S, output, 1, one-cycle set pulse to the downstream magnetron SR latch.
REQ-009 The block SHALL have port R, output, 1, one-cycle reset pulse to the downstream magnetron SR latch.
REQ-010 The block SHALL have port time_left, output, 12, remaining seconds.
REQ-011 The block SHALL have port done, output, 1, high while in DONE.
REQ-012 The block SHALL have port state, output, 2, IDLE=0, COOKING=1, PAUSED=2, DONE=3.

Function
REQ-013 Edge detection: start_edge = start & ~start_q and stop_edge = stop & ~stop_q, where start_q/stop_q are one-cycle registered copies.
REQ-014 All outputs SHALL be registered; S/R/state/time_left reflect the transition in the cycle after the triggering input edge is sampled.
REQ-015 IDLE -> COOKING on start_edge & door_closed & time_in != 0; time_left <= min(time_in, 3599); prescaler <= 0; S pulses 1.
REQ-016 IDLE with start_edge while door open or time_in == 0: remain IDLE, no pulse.
REQ-017 COOKING: prescaler increments each cycle; at CLK_PER_SEC-1 it wraps to 0 and time_left decrements by 1.
REQ-018 COOKING, decrement from 1 to 0 -> DONE; R pulses 1; done rises the same cycle.
REQ-019 COOKING, stop_edge -> IDLE; time_left <= 0; R pulses 1.
REQ-020 COOKING, door_closed = 0 -> PAUSED; time_left and prescaler frozen; R pulses 1.
REQ-021 PAUSED, start_edge & door_closed -> COOKING; prescaler resumes from frozen value; S pulses 1.
REQ-022 PAUSED, stop_edge -> IDLE; time_left <= 0; no pulse (latch already reset).
REQ-023 DONE: stop_edge or door_closed = 0 -> IDLE; done falls; no pulse; start ignored.
REQ-024 Priority in COOKING: stop_edge > door open > terminal count; exactly one transition and at most one R pulse per cycle.
REQ-025 Priority in PAUSED: stop_edge > start_edge.
REQ-026 S and R SHALL never be 1 in the same cycle; each pulse is exactly one cycle wide.
REQ-027 time_left SHALL never underflow; it never decrements outside COOKING.

Reset
REQ-028 While rst = 1: state = IDLE, S = 0, R = 0, done = 0, time_left = 0, prescaler = 0.
REQ-029 start_q and stop_q SHALL reset to 1, so a button held through reset produces no edge until released and re-pressed.
REQ-030 Reset asserted mid-COOKING SHALL drop to IDLE immediately without issuing R; the downstream latch is reset by its own reset path.

Verification (CLK_PER_SEC = 4)
REQ-031 time_in=3, door closed, press start -> S one pulse, state=1; time_left 3,2,1 at 4-cycle intervals; after 12 cycles R one pulse, state=3, done=1.
REQ-032 Cooking with time_left=5, open door -> R pulse, state=2, time_left holds 5; close door, press start -> S pulse, state=1, countdown resumes.
REQ-033 Cooking, stop and door open in the same cycle -> state=0, time_left=0, exactly one R pulse.
REQ-034 Idle with door open or time_in=0, press start -> no S, state stays 0; time_in=4000 -> time_left loads 3599.
REQ-035 DONE, press stop -> state=0, done=0, no pulse; start held through reset release -> no S until start is released and re-pressed.
REQ-036 Assert rst mid-COOKING -> all outputs 0 asynchronously, before the next clock edge.
